// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial addition controller:
//   state_t        controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  default operand/result width in bits
// -----------------------------------------------------------------------------
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_add_pkg

// File: rtl/FA_1_Bit_BH.sv
// -----------------------------------------------------------------------------
// FA_1_Bit_BH
// Behavioural 1-bit full adder, used as the shared serial datapath.
// Ports:
//   A, B, Cin  input  1-bit addends and carry-in
//   Sum        output sum bit
//   Cout       output carry-out
// -----------------------------------------------------------------------------
module FA_1_Bit_BH (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    always_comb begin
        {Cout, Sum} = {1'b0, A} + {1'b0, B} + {1'b0, Cin};
    end

endmodule : FA_1_Bit_BH

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder controller: latches a, b, cin on an accepted start, then
// feeds one bit pair per clock (LSB first) through a single shared 1-bit full
// adder, accumulating the sum MSB-first into a shift register. After WIDTH
// RUN cycles it presents {cout, sum} = a + b + cin with a one-cycle done pulse.
// Ports:
//   clk    input   rising-edge clock
//   rst    input   synchronous active-high reset (aborts any operation)
//   start  input   add request, sampled only in IDLE
//   a, b   input   WIDTH-bit operands, sampled on the accepted start edge
//   cin    input   carry-in, sampled on the accepted start edge
//   busy   output  high from acceptance until return to IDLE
//   done   output  one-cycle pulse, sum/cout valid
//   sum    output  WIDTH-bit result, held until the next accepted start
//   cout   output  final carry-out, held like sum
// All outputs are registered.
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH:0]   sum_ext;

    FA_1_Bit_BH u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .Sum  (fa_s),
        .Cout (fa_cout)
    );

    // Shift the new bit in at the MSB; taking [WIDTH:1] of the extended
    // vector stays legal even when WIDTH is 1.
    assign sum_ext = {fa_s, sum_q};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                sum_d   = sum_ext[WIDTH:1];
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    cout_d  = fa_cout;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl: a WIDTH=8 instance driven by a
// directed vector table, held-start, mid-operation reset and a random sweep,
// plus a WIDTH=1 instance exercised over the full-adder truth table.
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1;
    logic [0:0] a1, b1;
    logic       cin1;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec8_t;

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic sum;
        logic cout;
    } vec1_t;

    vec8_t vec8 [8];
    vec1_t vec1 [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full WIDTH=8 transaction starting from IDLE at a falling edge.
    // Operands are scrambled right after acceptance to show they are not reused.
    task automatic do_add8(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [7:0] esum, input logic ecout);
        int early;
        check({name, " idle_done"}, {31'd0, done8}, 32'd0);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = cin;
        tick();                                   // E0
        start8 = 1'b0; a8 = ~a; b8 = a ^ 8'h5A; cin8 = ~cin;
        check({name, " busy_e0"}, {31'd0, busy8}, 32'd1);
        early = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8 && done8) early++;
            if (k < 8 && !busy8) early++;
        end
        check({name, " early_done"}, early, 32'd0);
        check({name, " done_e8"}, {31'd0, done8}, 32'd1);
        check({name, " sum"}, {24'd0, sum8}, {24'd0, esum});
        check({name, " cout"}, {31'd0, cout8}, {31'd0, ecout});
        tick();                                   // E9
        check({name, " done_e9"}, {31'd0, done8}, 32'd0);
        check({name, " busy_e9"}, {31'd0, busy8}, 32'd0);
        check({name, " sum_hold"}, {24'd0, sum8}, {24'd0, esum});
    endtask

    initial begin
        int n_done;
        int last_done;
        int gap_bad;
        int spurious;
        logic [7:0] ra, rb;
        logic rc;
        logic [8:0] rexp;

        vec8[0] = '{"zero",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vec8[1] = '{"wrap",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vec8[2] = '{"3c_42_1", 8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0};
        vec8[3] = '{"max",     8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vec8[4] = '{"80_7f_1", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};
        vec8[5] = '{"a5_5a",   8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        vec8[6] = '{"12_34",   8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vec8[7] = '{"cin_only",8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

        vec1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vec1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vec1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vec1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vec1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vec1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;   // reset beats start
        start1 = 1'b1; a1 = 1'b1;  b1 = 1'b1;  cin1 = 1'b1;
        @(negedge clk);
        tick();
        tick();
        check("rst busy8", {31'd0, busy8}, 32'd0);
        check("rst done8", {31'd0, done8}, 32'd0);
        check("rst sum8",  {24'd0, sum8},  32'd0);
        check("rst cout8", {31'd0, cout8}, 32'd0);
        check("rst busy1", {31'd0, busy1}, 32'd0);
        check("rst sum1",  {31'd0, sum1},  32'd0);
        rst = 1'b0;
        start8 = 1'b0; start1 = 1'b0;
        tick();

        // Directed table, issued back-to-back at the earliest legal edge.
        for (int i = 0; i < 8; i++)
            do_add8(vec8[i].name, vec8[i].a, vec8[i].b, vec8[i].cin, vec8[i].sum, vec8[i].cout);

        // start held high: one done every 10 cycles, operand churn while busy.
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        n_done = 0; last_done = -1; gap_bad = 0;
        for (int k = 0; k < 45; k++) begin
            tick();
            if (done8) begin
                n_done++;
                check("held sum",  {24'd0, sum8},  32'd0);
                check("held cout", {31'd0, cout8}, 32'd1);
                if (last_done >= 0 && (k - last_done) != 10) gap_bad++;
                last_done = k;
                a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
            end else if (busy8) begin
                a8 = 8'h13 + 8'(k); b8 = 8'h7E; cin8 = 1'b1;
            end
        end
        check("held count", n_done, 32'd4);
        check("held gap", gap_bad, 32'd0);
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        check("held idle", {31'd0, busy8}, 32'd0);

        // Reset at E4 of 0x55+0xAA aborts without a done pulse.
        start8 = 1'b1; a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b0;
        tick();                                   // E0
        start8 = 1'b0;
        tick(); tick(); tick();                   // E1..E3
        rst = 1'b1;
        tick();                                   // E4
        rst = 1'b0;
        check("abort busy", {31'd0, busy8}, 32'd0);
        check("abort done", {31'd0, done8}, 32'd0);
        check("abort sum",  {24'd0, sum8},  32'd0);
        check("abort cout", {31'd0, cout8}, 32'd0);
        spurious = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done8 || busy8) spurious++;
        end
        check("abort no_done", spurious, 32'd0);
        do_add8("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // WIDTH=1: done one cycle after acceptance.
        for (int i = 0; i < 8; i++) begin
            check("w1 idle_done", {31'd0, done1}, 32'd0);
            start1 = 1'b1; a1 = vec1[i].a; b1 = vec1[i].b; cin1 = vec1[i].cin;
            tick();                               // E0
            start1 = 1'b0; a1 = ~vec1[i].a; b1 = ~vec1[i].b; cin1 = ~vec1[i].cin;
            check("w1 busy_e0", {31'd0, busy1}, 32'd1);
            check("w1 done_e0", {31'd0, done1}, 32'd0);
            tick();                               // E1
            check("w1 done_e1", {31'd0, done1}, 32'd1);
            check("w1 sum",  {31'd0, sum1},  {31'd0, vec1[i].sum});
            check("w1 cout", {31'd0, cout1}, {31'd0, vec1[i].cout});
            tick();                               // E2
            check("w1 done_e2", {31'd0, done1}, 32'd0);
            check("w1 busy_e2", {31'd0, busy1}, 32'd0);
        end

        // Random sweep.
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rexp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            do_add8("rand", ra, rb, rc, rexp[7:0], rexp[8]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_add_ctrl
